// File: rtl/pll_reconfig_pkg.sv
// Shared widths, FSM state encoding and completion status codes for the
// PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int unsigned VCO_MULT_W  = 7;
  localparam int unsigned VCO_INDIV_W = 7;
  localparam int unsigned OUT_IDX_W   = 3;
  localparam int unsigned OUT_DIV_W   = 8;
  localparam int unsigned OUT_PHASE_W = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_VCO,
    ST_VCO_WAIT,
    ST_OUT,
    ST_OUT_WAIT,
    ST_FINISH,
    ST_LOCK_WAIT,
    ST_RUN
  } pll_state_e;

  localparam logic [1:0] STATUS_OK           = 2'd0;
  localparam logic [1:0] STATUS_LOCK_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_CMD_TIMEOUT  = 2'd2;

endpackage

// File: rtl/pll_lock_debouncer.sv
// Two-flop synchroniser for the raw PLL lock plus a run-length counter;
// lock_stable needs LOCK_STABLE_CYCLES consecutive synchronised ones.
module pll_lock_debouncer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic lock_stable
);

  localparam int unsigned CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (!r_stable) begin
        if (r_cnt == CNT_LAST) r_stable <= 1'b1;
        else                   r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Gated by the synchroniser so the drop is seen on the first synchronised 0.
  assign lock_stable = r_stable & r_sync2;

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Programs a ReconfigurablePLL from a latched configuration, waits for a debounced
// lock with retries, and sequences per-domain resets. Optional lock_loss_count
// output is enabled by defining PLL_RECONFIG_SEQUENCER_LOSS_COUNTER_EN.
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS        = 6,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned CMD_TIMEOUT        = 256,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [VCO_MULT_W-1:0]           cfg_vco_mult,
  input  logic [VCO_INDIV_W-1:0]          cfg_vco_indiv,
  input  logic                            cfg_vco_bandwidth,
  input  logic [NUM_OUTPUTS-1:0]          cfg_out_en,
  input  logic [OUT_DIV_W*NUM_OUTPUTS-1:0]   cfg_out_div,
  input  logic [OUT_PHASE_W*NUM_OUTPUTS-1:0] cfg_out_phase,
  output logic                            done,
  output logic [1:0]                      status,
  output logic                            busy,
  output logic                            lock_lost,
  output logic [NUM_OUTPUTS-1:0]          domain_rst_n,
  input  logic                            pll_locked,
  output logic                            reconfig_start,
  output logic                            reconfig_finish,
  input  logic                            reconfig_cmd_done,
  output logic                            reconfig_vco_en,
  output logic [VCO_MULT_W-1:0]           reconfig_vco_mult,
  output logic [VCO_INDIV_W-1:0]          reconfig_vco_indiv,
  output logic                            reconfig_vco_bandwidth,
  output logic                            reconfig_output_en,
  output logic [OUT_IDX_W-1:0]            reconfig_output_idx,
  output logic [OUT_DIV_W-1:0]            reconfig_output_div,
  output logic [OUT_PHASE_W-1:0]          reconfig_output_phase
`ifdef PLL_RECONFIG_SEQUENCER_LOSS_COUNTER_EN
  ,
  output logic [15:0]                     lock_loss_count
`endif
);

  localparam int unsigned CMD_CNT_W  = $clog2(CMD_TIMEOUT + 1);
  localparam int unsigned LOCK_CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RETRY_W    = $clog2(MAX_RETRIES + 2);
  localparam logic [CMD_CNT_W-1:0]  CMD_LAST  = CMD_CNT_W'(CMD_TIMEOUT - 1);
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [OUT_IDX_W-1:0]  IDX_LAST  = OUT_IDX_W'(NUM_OUTPUTS - 1);

  pll_state_e              r_state;
  logic                    r_req_ready;
  logic                    r_done;
  logic [1:0]              r_status;
  logic                    r_lock_lost;
  logic [NUM_OUTPUTS-1:0]  r_domain_rst_n;
  logic                    r_start;
  logic                    r_finish;
  logic                    r_vco_en;
  logic [VCO_MULT_W-1:0]   r_vco_mult;
  logic [VCO_INDIV_W-1:0]  r_vco_indiv;
  logic                    r_vco_bw;
  logic                    r_out_en;
  logic [OUT_IDX_W-1:0]    r_out_idx;
  logic [OUT_DIV_W-1:0]    r_out_div;
  logic [OUT_PHASE_W-1:0]  r_out_phase;
  logic [CMD_CNT_W-1:0]    r_wait_cnt;
  logic [LOCK_CNT_W-1:0]   r_lock_cnt;
  logic [RETRY_W-1:0]      r_retry;
  logic [OUT_IDX_W-1:0]    r_idx;
  logic                    r_stable_d;

  logic [VCO_MULT_W-1:0]   r_cfg_mult;
  logic [VCO_INDIV_W-1:0]  r_cfg_indiv;
  logic                    r_cfg_bw;
  logic [NUM_OUTPUTS-1:0]  r_cfg_en;
  logic [OUT_DIV_W-1:0]    r_cfg_div   [NUM_OUTPUTS];
  logic [OUT_PHASE_W-1:0]  r_cfg_phase [NUM_OUTPUTS];

  logic w_lock_stable;
  logic w_lock_rise;
  logic w_idx_last;

  pll_lock_debouncer #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .lock_stable(w_lock_stable)
  );

  assign w_lock_rise = w_lock_stable & ~r_stable_d;
  assign w_idx_last  = (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= 1'b1;
      r_done         <= 1'b0;
      r_status       <= STATUS_OK;
      r_lock_lost    <= 1'b0;
      r_domain_rst_n <= '0;
      r_start        <= 1'b0;
      r_finish       <= 1'b0;
      r_vco_en       <= 1'b0;
      r_vco_mult     <= '0;
      r_vco_indiv    <= '0;
      r_vco_bw       <= 1'b0;
      r_out_en       <= 1'b0;
      r_out_idx      <= '0;
      r_out_div      <= '0;
      r_out_phase    <= '0;
      r_wait_cnt     <= '0;
      r_lock_cnt     <= '0;
      r_retry        <= '0;
      r_idx          <= '0;
      r_stable_d     <= 1'b0;
      r_cfg_mult     <= '0;
      r_cfg_indiv    <= '0;
      r_cfg_bw       <= 1'b0;
      r_cfg_en       <= '0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        r_cfg_div[i]   <= '0;
        r_cfg_phase[i] <= '0;
      end
    end else begin
      r_start    <= 1'b0;
      r_finish   <= 1'b0;
      r_vco_en   <= 1'b0;
      r_out_en   <= 1'b0;
      r_done     <= 1'b0;
      r_stable_d <= w_lock_stable;

      // Command pulses are registered, so each appears in the first cycle of the
      // state that waits on it; that cycle already accepts reconfig_cmd_done.
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (req_valid) begin
            r_cfg_mult     <= cfg_vco_mult;
            r_cfg_indiv    <= cfg_vco_indiv;
            r_cfg_bw       <= cfg_vco_bandwidth;
            r_cfg_en       <= cfg_out_en;
            for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
              r_cfg_div[i]   <= cfg_out_div[OUT_DIV_W*i +: OUT_DIV_W];
              r_cfg_phase[i] <= cfg_out_phase[OUT_PHASE_W*i +: OUT_PHASE_W];
            end
            r_lock_lost    <= 1'b0;
            r_retry        <= '0;
            r_domain_rst_n <= '0;
            r_req_ready    <= 1'b0;
            r_start        <= 1'b1;
            r_state        <= ST_START;
          end else if (r_state == ST_RUN && !w_lock_stable) begin
            r_domain_rst_n <= '0;
            r_lock_lost    <= 1'b1;
            r_state        <= ST_IDLE;
          end else if (r_state == ST_IDLE && w_lock_rise) begin
            r_domain_rst_n <= '1;
            r_state        <= ST_RUN;
          end
        end
        ST_START: begin
          r_vco_en    <= 1'b1;
          r_vco_mult  <= r_cfg_mult;
          r_vco_indiv <= r_cfg_indiv;
          r_vco_bw    <= r_cfg_bw;
          r_state     <= ST_VCO;
        end
        ST_VCO: begin
          if (reconfig_cmd_done) begin
            r_idx   <= '0;
            r_state <= ST_OUT;
          end else begin
            r_wait_cnt <= CMD_CNT_W'(1);
            r_state    <= ST_VCO_WAIT;
          end
        end
        ST_VCO_WAIT: begin
          if (reconfig_cmd_done) begin
            r_idx   <= '0;
            r_state <= ST_OUT;
          end else if (r_wait_cnt >= CMD_LAST) begin
            r_finish    <= 1'b1;
            r_done      <= 1'b1;
            r_status    <= STATUS_CMD_TIMEOUT;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (r_cfg_en[r_idx]) begin
            r_out_en    <= 1'b1;
            r_out_idx   <= r_idx;
            r_out_div   <= r_cfg_div[r_idx];
            r_out_phase <= r_cfg_phase[r_idx];
            r_wait_cnt  <= '0;
            r_state     <= ST_OUT_WAIT;
          end else if (w_idx_last) begin
            r_finish <= 1'b1;
            r_state  <= ST_FINISH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_OUT_WAIT: begin
          if (reconfig_cmd_done) begin
            if (w_idx_last) begin
              r_finish <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_OUT;
            end
          end else if (r_wait_cnt >= CMD_LAST) begin
            r_finish    <= 1'b1;
            r_done      <= 1'b1;
            r_status    <= STATUS_CMD_TIMEOUT;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          r_lock_cnt <= '0;
          r_state    <= ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (w_lock_stable) begin
            r_domain_rst_n <= '1;
            r_done         <= 1'b1;
            r_status       <= STATUS_OK;
            r_req_ready    <= 1'b1;
            r_state        <= ST_RUN;
          end else if (r_lock_cnt == LOCK_LAST) begin
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_start <= 1'b1;
              r_state <= ST_START;
            end else begin
              r_done      <= 1'b1;
              r_status    <= STATUS_LOCK_TIMEOUT;
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PLL_RECONFIG_SEQUENCER_LOSS_COUNTER_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (r_state == ST_RUN && !w_lock_stable && r_loss_cnt != '1) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign lock_loss_count = r_loss_cnt;
`endif

  assign req_ready              = r_req_ready;
  assign busy                   = ~r_req_ready;
  assign done                   = r_done;
  assign status                 = r_status;
  assign lock_lost              = r_lock_lost;
  assign domain_rst_n           = r_domain_rst_n;
  assign reconfig_start         = r_start;
  assign reconfig_finish        = r_finish;
  assign reconfig_vco_en        = r_vco_en;
  assign reconfig_vco_mult      = r_vco_mult;
  assign reconfig_vco_indiv     = r_vco_indiv;
  assign reconfig_vco_bandwidth = r_vco_bw;
  assign reconfig_output_en     = r_out_en;
  assign reconfig_output_idx    = r_out_idx;
  assign reconfig_output_div    = r_out_div;
  assign reconfig_output_phase  = r_out_phase;

endmodule
